sb_arbiter: RTL and testbench

Two-master arbiter for the system bus slave port. It shares the decoded peripheral/data-memory bus between master 0 (the core's LSU memory port) and master 1 (the UART program loader / DMA master). Each winner gets exclusive ownership for one complete transaction, ending on `s_ready_i`. A per-transaction watchdog stops a non-responding slave from hanging either master. The block sits between the masters and the address decoder / read-data mux.

---
 rtl/sb_arbiter.sv | 161 ++++++++++++++++
 tb/tb_sb_arbiter.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sb_arbiter.sv
// sb_arbiter: two-master arbiter in front of the system bus slave port.
//
// Master 0 (core LSU) and master 1 (UART loader / DMA) share a single slave
// port. The winner owns the bus for one complete transaction, which ends on
// s_ready_i, on a watchdog timeout (ready + err) or when the owner drops its
// request (abandon, no ready pulse). IDLE is always visited between two
// grants, so a transaction takes at least two cycles.
//
// Parameters
//   TIMEOUT    : BUSY cycles a transaction may wait for s_ready_i before it
//                is aborted with err; 0 disables the watchdog
//   FIXED_PRIO : 0 = round-robin on a tie, 1 = master 0 always wins a tie
//
// Ports
//   clk_i, resetn_i            : clock, synchronous active-low reset
//   mX_req/we/be/addr/wd_i     : master X request and transfer attributes
//   mX_rd_o/ready_o/err_o      : master X read data, completion, timeout flag
//   s_req/we/be/addr/wd_o      : request towards the address decoder
//   s_rd_i, s_ready_i          : read data / ready from the decoder mux
//   grant_o                    : one-hot current owner, 00 when IDLE
//
// States
//   IDLE    | no owner, arbitrate pending requests
//   BUSY_M0 | master 0 owns the slave port
//   BUSY_M1 | master 1 owns the slave port
module sb_arbiter #(
    parameter int TIMEOUT    = 255,
    parameter bit FIXED_PRIO = 1'b0
) (
    input  logic        clk_i,
    input  logic        resetn_i,

    input  logic        m0_req_i,
    input  logic        m0_we_i,
    input  logic [3:0]  m0_be_i,
    input  logic [31:0] m0_addr_i,
    input  logic [31:0] m0_wd_i,
    output logic [31:0] m0_rd_o,
    output logic        m0_ready_o,
    output logic        m0_err_o,

    input  logic        m1_req_i,
    input  logic        m1_we_i,
    input  logic [3:0]  m1_be_i,
    input  logic [31:0] m1_addr_i,
    input  logic [31:0] m1_wd_i,
    output logic [31:0] m1_rd_o,
    output logic        m1_ready_o,
    output logic        m1_err_o,

    output logic        s_req_o,
    output logic        s_we_o,
    output logic [3:0]  s_be_o,
    output logic [31:0] s_addr_o,
    output logic [31:0] s_wd_o,
    input  logic [31:0] s_rd_i,
    input  logic        s_ready_i,

    output logic [1:0]  grant_o
);

    localparam int CW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] WAIT_LAST = CW'((TIMEOUT > 0) ? (TIMEOUT - 1) : 0);

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] BUSY_M0 = 2'd1;
    localparam logic [1:0] BUSY_M1 = 2'd2;

    logic [1:0]    state_q, state_d;
    logic          last_q, last_d;          // 1: master 1 was granted last
    logic [CW-1:0] wait_cnt_q, wait_cnt_d;

    logic sel_m1;
    logic cur_req;
    logic timeout_hit;
    logic done_rdy;
    logic done_err;

    always_comb begin
        state_d     = state_q;
        last_d      = last_q;
        wait_cnt_d  = wait_cnt_q;
        done_rdy    = 1'b0;
        done_err    = 1'b0;
        sel_m1      = (state_q == BUSY_M1);
        cur_req     = sel_m1 ? m1_req_i : m0_req_i;
        timeout_hit = (TIMEOUT != 0) && (wait_cnt_q == WAIT_LAST);

        s_req_o     = 1'b0;
        s_we_o      = 1'b0;
        s_be_o      = 4'h0;
        s_addr_o    = 32'h0;
        s_wd_o      = 32'h0;
        grant_o     = 2'b00;

        case (state_q)
            IDLE: begin
                wait_cnt_d = '0;
                // On a tie the master that was not served last wins,
                // unless master 0 has fixed priority.
                if (m0_req_i && m1_req_i) begin
                    state_d = (FIXED_PRIO || last_q) ? BUSY_M0 : BUSY_M1;
                end else if (m0_req_i) begin
                    state_d = BUSY_M0;
                end else if (m1_req_i) begin
                    state_d = BUSY_M1;
                end
            end

            BUSY_M0, BUSY_M1: begin
                grant_o  = sel_m1 ? 2'b10 : 2'b01;
                s_req_o  = cur_req;
                s_we_o   = sel_m1 ? m1_we_i   : m0_we_i;
                s_be_o   = sel_m1 ? m1_be_i   : m0_be_i;
                s_addr_o = sel_m1 ? m1_addr_i : m0_addr_i;
                s_wd_o   = sel_m1 ? m1_wd_i   : m0_wd_i;

                if (!cur_req) begin
                    // Owner gave up: release silently, keep arbitration history.
                    state_d = IDLE;
                end else if (s_ready_i) begin
                    // A late ready on the timeout cycle still counts as success.
                    done_rdy = 1'b1;
                    last_d   = sel_m1;
                    state_d  = IDLE;
                end else if (timeout_hit) begin
                    done_rdy = 1'b1;
                    done_err = 1'b1;
                    last_d   = sel_m1;
                    state_d  = IDLE;
                end else begin
                    wait_cnt_d = wait_cnt_q + 1'b1;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase

        m0_ready_o = done_rdy && (state_q == BUSY_M0);
        m0_err_o   = done_err && (state_q == BUSY_M0);
        m1_ready_o = done_rdy && (state_q == BUSY_M1);
        m1_err_o   = done_err && (state_q == BUSY_M1);
        m0_rd_o    = ((state_q == BUSY_M0) && !done_err) ? s_rd_i : 32'h0;
        m1_rd_o    = ((state_q == BUSY_M1) && !done_err) ? s_rd_i : 32'h0;
    end

    always_ff @(posedge clk_i) begin
        if (!resetn_i) begin
            state_q    <= IDLE;
            last_q     <= 1'b1;
            wait_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            last_q     <= last_d;
            wait_cnt_q <= wait_cnt_d;
        end
    end

endmodule

// File: tb/tb_sb_arbiter.sv
module tb_sb_arbiter;

    localparam logic [31:0] A0  = 32'h0200_0000;
    localparam logic [31:0] A1  = 32'h3000_0010;
    localparam logic [31:0] WD0 = 32'h1111_0000;
    localparam logic [31:0] WD1 = 32'hCAFE_0000;
    localparam logic [3:0]  BE0 = 4'hF;
    localparam logic [3:0]  BE1 = 4'h3;
    localparam logic        WE0 = 1'b0;
    localparam logic        WE1 = 1'b1;

    logic        clk_i = 1'b0;
    logic        resetn_i;
    logic        m0_req_i, m1_req_i;
    logic        m0_we_i, m1_we_i;
    logic [3:0]  m0_be_i, m1_be_i;
    logic [31:0] m0_addr_i, m1_addr_i, m0_wd_i, m1_wd_i;
    logic [31:0] s_rd_i;
    logic        s_ready_i;

    // main DUT: TIMEOUT=4, round-robin
    logic [31:0] m0_rd_a, m1_rd_a, s_addr_a, s_wd_a;
    logic        m0_ready_a, m0_err_a, m1_ready_a, m1_err_a, s_req_a, s_we_a;
    logic [3:0]  s_be_a;
    logic [1:0]  grant_a;
    // fixed priority DUT
    logic [31:0] m0_rd_f, m1_rd_f, s_addr_f, s_wd_f;
    logic        m0_ready_f, m0_err_f, m1_ready_f, m1_err_f, s_req_f, s_we_f;
    logic [3:0]  s_be_f;
    logic [1:0]  grant_f;
    // watchdog disabled DUT
    logic [31:0] m0_rd_n, m1_rd_n, s_addr_n, s_wd_n;
    logic        m0_ready_n, m0_err_n, m1_ready_n, m1_err_n, s_req_n, s_we_n;
    logic [3:0]  s_be_n;
    logic [1:0]  grant_n;

    always #5 clk_i = ~clk_i;

    sb_arbiter #(.TIMEOUT(4), .FIXED_PRIO(1'b0)) dut (
        .clk_i(clk_i), .resetn_i(resetn_i),
        .m0_req_i(m0_req_i), .m0_we_i(m0_we_i), .m0_be_i(m0_be_i), .m0_addr_i(m0_addr_i),
        .m0_wd_i(m0_wd_i), .m0_rd_o(m0_rd_a), .m0_ready_o(m0_ready_a), .m0_err_o(m0_err_a),
        .m1_req_i(m1_req_i), .m1_we_i(m1_we_i), .m1_be_i(m1_be_i), .m1_addr_i(m1_addr_i),
        .m1_wd_i(m1_wd_i), .m1_rd_o(m1_rd_a), .m1_ready_o(m1_ready_a), .m1_err_o(m1_err_a),
        .s_req_o(s_req_a), .s_we_o(s_we_a), .s_be_o(s_be_a), .s_addr_o(s_addr_a),
        .s_wd_o(s_wd_a), .s_rd_i(s_rd_i), .s_ready_i(s_ready_i), .grant_o(grant_a));

    sb_arbiter #(.TIMEOUT(4), .FIXED_PRIO(1'b1)) dut_fp (
        .clk_i(clk_i), .resetn_i(resetn_i),
        .m0_req_i(m0_req_i), .m0_we_i(m0_we_i), .m0_be_i(m0_be_i), .m0_addr_i(m0_addr_i),
        .m0_wd_i(m0_wd_i), .m0_rd_o(m0_rd_f), .m0_ready_o(m0_ready_f), .m0_err_o(m0_err_f),
        .m1_req_i(m1_req_i), .m1_we_i(m1_we_i), .m1_be_i(m1_be_i), .m1_addr_i(m1_addr_i),
        .m1_wd_i(m1_wd_i), .m1_rd_o(m1_rd_f), .m1_ready_o(m1_ready_f), .m1_err_o(m1_err_f),
        .s_req_o(s_req_f), .s_we_o(s_we_f), .s_be_o(s_be_f), .s_addr_o(s_addr_f),
        .s_wd_o(s_wd_f), .s_rd_i(s_rd_i), .s_ready_i(s_ready_i), .grant_o(grant_f));

    sb_arbiter #(.TIMEOUT(0), .FIXED_PRIO(1'b0)) dut_nt (
        .clk_i(clk_i), .resetn_i(resetn_i),
        .m0_req_i(m0_req_i), .m0_we_i(m0_we_i), .m0_be_i(m0_be_i), .m0_addr_i(m0_addr_i),
        .m0_wd_i(m0_wd_i), .m0_rd_o(m0_rd_n), .m0_ready_o(m0_ready_n), .m0_err_o(m0_err_n),
        .m1_req_i(m1_req_i), .m1_we_i(m1_we_i), .m1_be_i(m1_be_i), .m1_addr_i(m1_addr_i),
        .m1_wd_i(m1_wd_i), .m1_rd_o(m1_rd_n), .m1_ready_o(m1_ready_n), .m1_err_o(m1_err_n),
        .s_req_o(s_req_n), .s_we_o(s_we_n), .s_be_o(s_be_n), .s_addr_o(s_addr_n),
        .s_wd_o(s_wd_n), .s_rd_i(s_rd_i), .s_ready_i(s_ready_i), .grant_o(grant_n));

    typedef struct {
        logic       rst_n;
        logic       r0;
        logic       r1;
        logic       srdy;
        logic [1:0] grant;
        logic       sreq;
        logic       rdy0;
        logic       err0;
        logic       rdy1;
        logic       err1;
    } vec_t;

    vec_t vecs[$];
    int   checks   = 0;
    int   failures = 0;

    function automatic vec_t mk(input logic rst_n, input logic r0, input logic r1,
                                input logic srdy, input logic [1:0] grant, input logic sreq,
                                input logic rdy0, input logic err0, input logic rdy1,
                                input logic err1);
        vec_t v;
        v.rst_n = rst_n; v.r0 = r0; v.r1 = r1; v.srdy = srdy;
        v.grant = grant; v.sreq = sreq;
        v.rdy0 = rdy0; v.err0 = err0; v.rdy1 = rdy1; v.err1 = err1;
        return v;
    endfunction

    task automatic chk(input string what, input int row, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s row %0d: got %h expected %h", what, row, act, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk_i);
        resetn_i = 1'b0; m0_req_i = 1'b0; m1_req_i = 1'b0; s_ready_i = 1'b0;
        repeat (2) @(negedge clk_i);
        resetn_i = 1'b1;
    endtask

    initial begin
        int c0a, c1a, c0f, c1f, nt_pulses, to_a;
        logic [31:0] e_addr, e_wd, e_rd0, e_rd1;
        logic [3:0]  e_be;
        logic        e_we;

        resetn_i  = 1'b0;
        m0_req_i  = 1'b0; m1_req_i = 1'b0;
        m0_we_i   = WE0;  m1_we_i  = WE1;
        m0_be_i   = BE0;  m1_be_i  = BE1;
        m0_addr_i = A0;   m1_addr_i = A1;
        m0_wd_i   = WD0;  m1_wd_i   = WD1;
        s_rd_i    = 32'h0;
        s_ready_i = 1'b0;

        //                rst r0 r1 rdy grant sreq rdy0 err0 rdy1 err1
        vecs.push_back(mk(1, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0)); // 0  reset state
        vecs.push_back(mk(1, 1, 0, 0, 2'b00, 0, 0, 0, 0, 0)); // 1  M0 request seen
        vecs.push_back(mk(1, 1, 0, 0, 2'b01, 1, 0, 0, 0, 0)); // 2  one wait cycle
        vecs.push_back(mk(1, 1, 0, 1, 2'b01, 1, 1, 0, 0, 0)); // 3  M0 done
        vecs.push_back(mk(1, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0)); // 4
        vecs.push_back(mk(1, 1, 1, 1, 2'b00, 0, 0, 0, 0, 0)); // 5  tie, last=M0
        vecs.push_back(mk(1, 1, 1, 1, 2'b10, 1, 0, 0, 1, 0)); // 6
        vecs.push_back(mk(1, 1, 1, 1, 2'b00, 0, 0, 0, 0, 0)); // 7
        vecs.push_back(mk(1, 1, 1, 1, 2'b01, 1, 1, 0, 0, 0)); // 8
        vecs.push_back(mk(1, 1, 1, 1, 2'b00, 0, 0, 0, 0, 0)); // 9
        vecs.push_back(mk(1, 1, 1, 1, 2'b10, 1, 0, 0, 1, 0)); // 10
        vecs.push_back(mk(1, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0)); // 11
        vecs.push_back(mk(1, 0, 1, 0, 2'b00, 0, 0, 0, 0, 0)); // 12 M1 write, dead slave
        vecs.push_back(mk(1, 0, 1, 0, 2'b10, 1, 0, 0, 0, 0)); // 13
        vecs.push_back(mk(1, 0, 1, 0, 2'b10, 1, 0, 0, 0, 0)); // 14
        vecs.push_back(mk(1, 0, 1, 0, 2'b10, 1, 0, 0, 0, 0)); // 15
        vecs.push_back(mk(1, 0, 1, 0, 2'b10, 1, 0, 0, 1, 1)); // 16 timeout
        vecs.push_back(mk(1, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0)); // 17
        vecs.push_back(mk(1, 0, 1, 0, 2'b00, 0, 0, 0, 0, 0)); // 18
        vecs.push_back(mk(1, 0, 1, 1, 2'b10, 1, 0, 0, 1, 0)); // 19 clean after timeout
        vecs.push_back(mk(1, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0)); // 20
        vecs.push_back(mk(1, 1, 0, 0, 2'b00, 0, 0, 0, 0, 0)); // 21
        vecs.push_back(mk(1, 1, 0, 0, 2'b01, 1, 0, 0, 0, 0)); // 22
        vecs.push_back(mk(1, 1, 0, 0, 2'b01, 1, 0, 0, 0, 0)); // 23
        vecs.push_back(mk(1, 1, 0, 0, 2'b01, 1, 0, 0, 0, 0)); // 24
        vecs.push_back(mk(1, 1, 0, 1, 2'b01, 1, 1, 0, 0, 0)); // 25 ready on timeout cycle
        vecs.push_back(mk(1, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0)); // 26
        vecs.push_back(mk(1, 1, 0, 0, 2'b00, 0, 0, 0, 0, 0)); // 27
        vecs.push_back(mk(1, 1, 1, 0, 2'b01, 1, 0, 0, 0, 0)); // 28 isolation
        vecs.push_back(mk(1, 0, 1, 0, 2'b01, 0, 0, 0, 0, 0)); // 29 M0 abandons
        vecs.push_back(mk(1, 0, 1, 0, 2'b00, 0, 0, 0, 0, 0)); // 30
        vecs.push_back(mk(1, 0, 1, 1, 2'b10, 1, 0, 0, 1, 0)); // 31 M1 granted
        vecs.push_back(mk(1, 1, 1, 0, 2'b00, 0, 0, 0, 0, 0)); // 32 tie, last=M1
        vecs.push_back(mk(1, 0, 1, 0, 2'b01, 0, 0, 0, 0, 0)); // 33 M0 abandons
        vecs.push_back(mk(1, 1, 1, 0, 2'b00, 0, 0, 0, 0, 0)); // 34 last still M1
        vecs.push_back(mk(1, 1, 1, 1, 2'b01, 1, 1, 0, 0, 0)); // 35
        vecs.push_back(mk(1, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0)); // 36
        vecs.push_back(mk(1, 0, 1, 0, 2'b00, 0, 0, 0, 0, 0)); // 37
        vecs.push_back(mk(0, 0, 1, 0, 2'b10, 1, 0, 0, 0, 0)); // 38 reset in BUSY_M1
        vecs.push_back(mk(1, 1, 1, 0, 2'b00, 0, 0, 0, 0, 0)); // 39 tie after reset
        vecs.push_back(mk(1, 1, 1, 1, 2'b01, 1, 1, 0, 0, 0)); // 40 M0 wins
        vecs.push_back(mk(1, 0, 1, 0, 2'b00, 0, 0, 0, 0, 0)); // 41
        vecs.push_back(mk(1, 0, 1, 1, 2'b10, 1, 0, 0, 1, 0)); // 42
        vecs.push_back(mk(1, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0)); // 43

        repeat (2) @(posedge clk_i);

        foreach (vecs[i]) begin
            @(negedge clk_i);
            resetn_i  = vecs[i].rst_n;
            m0_req_i  = vecs[i].r0;
            m1_req_i  = vecs[i].r1;
            s_ready_i = vecs[i].srdy;
            s_rd_i    = 32'h1234_0000 | 32'(i);
            #1;
            e_addr = (vecs[i].grant == 2'b01) ? A0  : (vecs[i].grant == 2'b10) ? A1  : 32'h0;
            e_wd   = (vecs[i].grant == 2'b01) ? WD0 : (vecs[i].grant == 2'b10) ? WD1 : 32'h0;
            e_be   = (vecs[i].grant == 2'b01) ? BE0 : (vecs[i].grant == 2'b10) ? BE1 : 4'h0;
            e_we   = (vecs[i].grant == 2'b01) ? WE0 : (vecs[i].grant == 2'b10) ? WE1 : 1'b0;
            e_rd0  = (vecs[i].grant == 2'b01 && !vecs[i].err0) ? s_rd_i : 32'h0;
            e_rd1  = (vecs[i].grant == 2'b10 && !vecs[i].err1) ? s_rd_i : 32'h0;
            chk("grant",    i, 32'(grant_a),    32'(vecs[i].grant));
            chk("s_req",    i, 32'(s_req_a),    32'(vecs[i].sreq));
            chk("s_addr",   i, s_addr_a,        e_addr);
            chk("s_wd",     i, s_wd_a,          e_wd);
            chk("s_be",     i, 32'(s_be_a),     32'(e_be));
            chk("s_we",     i, 32'(s_we_a),     32'(e_we));
            chk("m0_ready", i, 32'(m0_ready_a), 32'(vecs[i].rdy0));
            chk("m0_err",   i, 32'(m0_err_a),   32'(vecs[i].err0));
            chk("m1_ready", i, 32'(m1_ready_a), 32'(vecs[i].rdy1));
            chk("m1_err",   i, 32'(m1_err_a),   32'(vecs[i].err1));
            chk("m0_rd",    i, m0_rd_a,         e_rd0);
            chk("m1_rd",    i, m1_rd_a,         e_rd1);
        end

        // Continuous tie with a zero-wait slave: round-robin alternates,
        // fixed priority serves only master 0.
        do_reset();
        c0a = 0; c1a = 0; c0f = 0; c1f = 0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk_i);
            m0_req_i = 1'b1; m1_req_i = 1'b1; s_ready_i = 1'b1;
            #1;
            c0a += int'(m0_ready_a); c1a += int'(m1_ready_a);
            c0f += int'(m0_ready_f); c1f += int'(m1_ready_f);
        end
        chk("rr_m0_done",  100, 32'(c0a), 32'd2);
        chk("rr_m1_done",  100, 32'(c1a), 32'd2);
        chk("fp_m0_done",  100, 32'(c0f), 32'd4);
        chk("fp_m1_done",  100, 32'(c1f), 32'd0);

        // Dead slave: TIMEOUT=4 aborts twice in 10 cycles, TIMEOUT=0 keeps waiting.
        @(negedge clk_i);
        m0_req_i = 1'b0; m1_req_i = 1'b0; s_ready_i = 1'b0;
        nt_pulses = 0; to_a = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk_i);
            m0_req_i = 1'b1;
            #1;
            nt_pulses += int'(m0_ready_n) + int'(m0_err_n);
            to_a      += int'(m0_ready_a && m0_err_a);
        end
        chk("nt_no_pulse", 101, 32'(nt_pulses), 32'd0);
        chk("nt_grant",    101, 32'(grant_n),   32'(2'b01));
        chk("to_count",    101, 32'(to_a),      32'd2);

        @(negedge clk_i);
        m0_req_i = 1'b0;
        @(negedge clk_i);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
